fe_instr_q: RTL and testbench

Instruction queue between fetch and decode. Decouples fetch from decode back-pressure: it accepts packets presented on `valid_fe1`/`instr_fe1`, holds up to `DEPTH` of them in order, and presents the oldest to decode. It back-pressures fetch through `stall` and discards all contents on a branch mispredict redirect.

---
 rtl/fe_instr_q_pkg.sv | 13 +
 rtl/fe_instr_q_fifo_ptr.sv | 70 +++++++
 rtl/fe_instr_q.sv | 72 +++++++
 tb/tb_fe_instr_q.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fe_instr_q_pkg.sv
// Shared types and sizing for the fetch-to-decode instruction queue.
// t_instr_pkt is the fetch packet carried unchanged from fetch to decode.
package fe_instr_q_pkg;

    localparam int IQ_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  simid;
    } t_instr_pkt;

endpackage

// File: rtl/fe_instr_q_fifo_ptr.sv
// Generic wrap-bit read/write pointer pair with a registered full flag.
// Also intended for reuse by the fe_buf fill queues.
module fe_instr_q_fifo_ptr #(
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(DEPTH),
    localparam int PW    = IW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [IW-1:0] wr_idx_o,
    output logic [IW-1:0] rd_idx_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [PW-1:0] occ_o
);

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] occ_d;
    logic          full_q, full_d;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
        end
        // Full is computed from next-state occupancy so it can be a flop output.
        occ_d  = wr_d - rd_d;
        full_d = (occ_d == PW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            full_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            full_q <= full_d;
        end
    end

    assign wr_idx_o = wr_q[IW-1:0];
    assign rd_idx_o = rd_q[IW-1:0];
    assign empty_o  = (wr_q == rd_q);
    assign full_o   = full_q;
    assign occ_o    = wr_q - rd_q;

`ifdef ASSERT
    logic full_ptr;
    assign full_ptr = (wr_q[IW-1:0] == rd_q[IW-1:0]) && (wr_q[IW] != rd_q[IW]);

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
        push_i && !flush_i |-> !full_ptr);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
        pop_i && !flush_i |-> !empty_o);
    a_full_flag: assert property (@(posedge clk) disable iff (!reset_n)
        full_q == full_ptr);
`endif

endmodule

// File: rtl/fe_instr_q.sv
// Instruction queue between fetch and decode: in-order buffering, fetch
// back-pressure via a registered stall, and flush on branch mispredict.
module fe_instr_q
    import fe_instr_q_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH,
    localparam int IW    = $clog2(DEPTH),
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          valid_fe1,
    input  t_instr_pkt    instr_fe1,
    output logic          stall,
    input  logic          br_mispred_rb1,
    output logic          valid_iq,
    output t_instr_pkt    instr_iq,
    input  logic          stall_de,
    output logic [OW-1:0] occ_iq
);

    logic          push, pop, empty, full;
    logic [IW-1:0] wr_idx, rd_idx;
    t_instr_pkt    mem_q [DEPTH];

    // stall is the registered full flag, so a pop never frees a slot in the same cycle.
    assign push     = valid_fe1 & ~stall & ~br_mispred_rb1;
    assign valid_iq = ~empty & ~br_mispred_rb1;
    assign pop      = valid_iq & ~stall_de;
    assign stall    = full;
    assign instr_iq = mem_q[rd_idx];

    fe_instr_q_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_i   (push),
        .pop_i    (pop),
        .flush_i  (br_mispred_rb1),
        .wr_idx_o (wr_idx),
        .rd_idx_o (rd_idx),
        .empty_o  (empty),
        .full_o   (full),
        .occ_o    (occ_iq)
    );

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= instr_fe1;
    end

`ifdef ASSERT
    logic [7:0] last_simid_q;
    logic       seen_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_simid_q <= '0;
            seen_q       <= 1'b0;
        end else if (br_mispred_rb1) begin
            seen_q       <= 1'b0;
        end else if (pop) begin
            last_simid_q <= instr_iq.simid;
            seen_q       <= 1'b1;
        end
    end

    a_fe_hold: assert property (@(posedge clk) disable iff (!reset_n)
        valid_fe1 && stall && !br_mispred_rb1 |=> $stable(instr_fe1));
    a_simid_mono: assert property (@(posedge clk) disable iff (!reset_n)
        pop && seen_q |-> ($signed(instr_iq.simid - last_simid_q) > 0));
`endif

endmodule

// File: tb/tb_fe_instr_q.sv
// Directed bench for fe_instr_q (DEPTH=4): reset, fill/stall, streaming,
// flush and asynchronous reset, each step checked against hand-computed values.
module tb_fe_instr_q;
    import fe_instr_q_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       valid_fe1;
    t_instr_pkt instr_fe1;
    logic       stall;
    logic       br_mispred_rb1;
    logic       valid_iq;
    t_instr_pkt instr_iq;
    logic       stall_de;
    logic [2:0] occ_iq;

    int n_assert = 0;
    int n_fail   = 0;

    fe_instr_q #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_fe1      (valid_fe1),
        .instr_fe1      (instr_fe1),
        .stall          (stall),
        .br_mispred_rb1 (br_mispred_rb1),
        .valid_iq       (valid_iq),
        .instr_iq       (instr_iq),
        .stall_de       (stall_de),
        .occ_iq         (occ_iq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic t_instr_pkt mk(input logic [31:0] pc, input logic [7:0] simid);
        t_instr_pkt p;
        p.pc    = pc;
        p.instr = 32'h0000_0013 ^ pc;
        p.simid = simid;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        valid_fe1      = 1'b0;
        instr_fe1      = '0;
        br_mispred_rb1 = 1'b0;
        stall_de       = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_valid", 32'(valid_iq), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_occ", 32'(occ_iq), 32'd0);
        reset_n = 1'b1;
        step();

        // Single push, visible next cycle, popped immediately
        valid_fe1 = 1'b1;
        instr_fe1 = mk(32'h100, 8'd1);
        step();
        valid_fe1 = 1'b0;
        chk("one_valid", 32'(valid_iq), 32'd1);
        chk("one_pc", instr_iq.pc, 32'h100);
        chk("one_occ", 32'(occ_iq), 32'd1);
        step();
        chk("one_occ_after", 32'(occ_iq), 32'd0);
        chk("one_valid_after", 32'(valid_iq), 32'd0);

        // Fill to full with decode stalled
        stall_de = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_fe1 = 1'b1;
            instr_fe1 = mk(32'h100 + 32'(4 * i), 8'(2 + i));
            step();
            chk("fill_occ", 32'(occ_iq), 32'(i + 1));
            chk("fill_stall", 32'(stall), 32'(i == 3));
        end
        instr_fe1 = mk(32'h110, 8'd6);
        step();
        step();
        chk("full_occ", 32'(occ_iq), 32'd4);
        chk("full_stall", 32'(stall), 32'd1);
        chk("full_head", instr_iq.pc, 32'h100);

        // Drain: first pop from full rejects the held push
        stall_de = 1'b0;
        step();
        chk("drain_occ0", 32'(occ_iq), 32'd3);
        chk("drain_stall0", 32'(stall), 32'd0);
        chk("drain_pc0", instr_iq.pc, 32'h104);
        step();
        valid_fe1 = 1'b0;
        chk("drain_occ1", 32'(occ_iq), 32'd3);
        chk("drain_pc1", instr_iq.pc, 32'h108);
        step();
        chk("drain_occ2", 32'(occ_iq), 32'd2);
        chk("drain_pc2", instr_iq.pc, 32'h10C);
        step();
        chk("drain_occ3", 32'(occ_iq), 32'd1);
        chk("drain_pc3", instr_iq.pc, 32'h110);
        step();
        chk("drain_occ4", 32'(occ_iq), 32'd0);
        chk("drain_valid4", 32'(valid_iq), 32'd0);

        // Streaming at occupancy 1
        for (int k = 0; k < 6; k++) begin
            valid_fe1 = 1'b1;
            instr_fe1 = mk(32'h300 + 32'(4 * k), 8'(10 + k));
            step();
            chk("strm_occ", 32'(occ_iq), 32'd1);
            chk("strm_stall", 32'(stall), 32'd0);
            chk("strm_valid", 32'(valid_iq), 32'd1);
            chk("strm_pc", instr_iq.pc, 32'h300 + 32'(4 * k));
        end
        valid_fe1 = 1'b0;
        step();
        chk("strm_end_occ", 32'(occ_iq), 32'd0);

        // Flush at occupancy 3 with concurrent push and pop
        stall_de = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_fe1 = 1'b1;
            instr_fe1 = mk(32'h400 + 32'(4 * i), 8'(20 + i));
            step();
        end
        chk("pre_flush_occ", 32'(occ_iq), 32'd3);
        instr_fe1      = mk(32'h40C, 8'd23);
        stall_de       = 1'b0;
        br_mispred_rb1 = 1'b1;
        #1;
        chk("flush_mask_valid", 32'(valid_iq), 32'd0);
        step();
        br_mispred_rb1 = 1'b0;
        instr_fe1      = mk(32'h200, 8'd24);
        chk("flush_n1_valid", 32'(valid_iq), 32'd0);
        chk("flush_n1_occ", 32'(occ_iq), 32'd0);
        chk("flush_n1_stall", 32'(stall), 32'd0);
        step();
        valid_fe1 = 1'b0;
        chk("post_flush_valid", 32'(valid_iq), 32'd1);
        chk("post_flush_pc", instr_iq.pc, 32'h200);
        chk("post_flush_occ", 32'(occ_iq), 32'd1);
        step();
        chk("post_flush_drain", 32'(occ_iq), 32'd0);

        // Flush while full clears stall next cycle
        stall_de = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_fe1 = 1'b1;
            instr_fe1 = mk(32'h500 + 32'(4 * i), 8'(25 + i));
            step();
        end
        valid_fe1 = 1'b0;
        chk("ff_stall", 32'(stall), 32'd1);
        br_mispred_rb1 = 1'b1;
        step();
        br_mispred_rb1 = 1'b0;
        chk("ff_stall_clr", 32'(stall), 32'd0);
        chk("ff_occ", 32'(occ_iq), 32'd0);

        // Asynchronous reset mid-stream at occupancy 2
        for (int i = 0; i < 2; i++) begin
            valid_fe1 = 1'b1;
            instr_fe1 = mk(32'h600 + 32'(4 * i), 8'(30 + i));
            step();
        end
        valid_fe1 = 1'b0;
        chk("ar_pre_occ", 32'(occ_iq), 32'd2);
        chk("ar_pre_valid", 32'(valid_iq), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(valid_iq), 32'd0);
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_occ", 32'(occ_iq), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("ar_after_occ", 32'(occ_iq), 32'd0);

        // Queue operational again after reset
        stall_de  = 1'b0;
        valid_fe1 = 1'b1;
        instr_fe1 = mk(32'h700, 8'd40);
        step();
        valid_fe1 = 1'b0;
        chk("rr_valid", 32'(valid_iq), 32'd1);
        chk("rr_pc", instr_iq.pc, 32'h700);
        chk("rr_simid", 32'(instr_iq.simid), 32'd40);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
